// File: rtl/viterbi_acs_unit.sv
// Add-compare-select stage for the 4-state (7,5) K=3 Viterbi decoder.
// Normalized path metrics, per-step survivor decisions, and frame tracking with best end state.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for in_valid & start; path metrics are stale
// RUN   | frame in progress; each in_valid is one trellis step
module viterbi_acs_unit #(
    parameter int PM_W      = 12,
    parameter int FRAME_LEN = 64,
    parameter int INIT_PM   = 1024
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    input  logic                   start,
    input  logic signed [7:0]      edge_00,
    input  logic signed [7:0]      edge_11,
    input  logic signed [7:0]      edge_10,
    input  logic signed [7:0]      edge_01,
    output logic                   dec_valid,
    output logic [3:0]             dec,
    output logic                   dec_last,
    output logic [1:0]             best_state,
    output logic [4*PM_W-1:0]      pm,
    output logic                   busy
);
    localparam int CNT_W = 12;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic signed [PM_W-1:0] INIT_V = PM_W'(INIT_PM);
    localparam logic signed [PM_W+1:0] SAT_HI = {3'b000, {(PM_W-1){1'b1}}};
    localparam logic signed [PM_W+1:0] SAT_LO = {3'b111, {(PM_W-1){1'b0}}};

    logic [0:0]              state;
    logic [CNT_W-1:0]        step_cnt;
    logic signed [PM_W-1:0]  pm_q [4];

    logic                    init_now;
    logic                    accept;
    logic                    last_n;
    logic signed [PM_W-1:0]  cur [4];
    logic signed [PM_W-1:0]  min_a;
    logic signed [PM_W-1:0]  min_b;
    logic signed [PM_W-1:0]  min_cur;
    logic signed [7:0]       br0 [4];
    logic signed [7:0]       br1 [4];
    logic signed [PM_W:0]    c0 [4];
    logic signed [PM_W:0]    c1 [4];
    logic signed [PM_W:0]    sel [4];
    logic signed [PM_W+1:0]  diff [4];
    logic signed [PM_W-1:0]  pm_n [4];
    logic [3:0]              dec_n;
    logic [1:0]              best_n;
    logic signed [PM_W-1:0]  best_pm;

    always_comb begin
        init_now = in_valid & start;
        accept   = in_valid & (start | (state == ST_RUN));
        last_n   = (state == ST_RUN) & ~start & (step_cnt == LAST_CNT);
    end

    // A start step always runs from the initial metrics, even mid-frame.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cur[i] = pm_q[i];
            if (init_now) begin
                cur[i] = (i == 0) ? '0 : INIT_V;
            end
        end
    end

    always_comb begin
        min_a   = (cur[1] < cur[0]) ? cur[1] : cur[0];
        min_b   = (cur[3] < cur[2]) ? cur[3] : cur[2];
        min_cur = (min_b < min_a) ? min_b : min_a;
    end

    always_comb begin
        br0[0] = edge_00;  br1[0] = edge_11;
        br0[1] = edge_10;  br1[1] = edge_01;
        br0[2] = edge_11;  br1[2] = edge_00;
        br0[3] = edge_01;  br1[3] = edge_10;
    end

    // Predecessors of next state {u,a} are {a,0} and {a,1}.
    always_comb begin
        dec_n = '0;
        for (int s = 0; s < 4; s++) begin
            c0[s] = $signed({cur[{s[0], 1'b0}][PM_W-1], cur[{s[0], 1'b0}]})
                  + $signed({{(PM_W-7){br0[s][7]}}, br0[s]});
            c1[s] = $signed({cur[{s[0], 1'b1}][PM_W-1], cur[{s[0], 1'b1}]})
                  + $signed({{(PM_W-7){br1[s][7]}}, br1[s]});
            dec_n[s] = (c1[s] < c0[s]);
            sel[s]   = dec_n[s] ? c1[s] : c0[s];
            diff[s]  = $signed({sel[s][PM_W], sel[s]})
                     - $signed({{2{min_cur[PM_W-1]}}, min_cur});
            if (diff[s] > SAT_HI) begin
                pm_n[s] = SAT_HI[PM_W-1:0];
            end else if (diff[s] < SAT_LO) begin
                pm_n[s] = SAT_LO[PM_W-1:0];
            end else begin
                pm_n[s] = diff[s][PM_W-1:0];
            end
        end
    end

    always_comb begin
        best_n  = 2'd0;
        best_pm = pm_n[0];
        for (int i = 1; i < 4; i++) begin
            if (pm_n[i] < best_pm) begin
                best_pm = pm_n[i];
                best_n  = 2'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            step_cnt   <= '0;
            dec_valid  <= 1'b0;
            dec        <= '0;
            dec_last   <= 1'b0;
            best_state <= '0;
            for (int i = 0; i < 4; i++) begin
                pm_q[i] <= '0;
            end
        end else begin
            dec_valid <= accept;
            dec_last  <= accept & last_n;
            if (accept) begin
                dec        <= dec_n;
                best_state <= best_n;
                for (int i = 0; i < 4; i++) begin
                    pm_q[i] <= pm_n[i];
                end
                if (last_n) begin
                    state    <= ST_IDLE;
                    step_cnt <= '0;
                end else begin
                    state    <= ST_RUN;
                    step_cnt <= init_now ? CNT_W'(1) : step_cnt + CNT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_pm
        assign pm[g*PM_W +: PM_W] = pm_q[g];
    end

    assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_viterbi_acs_unit.sv
// Scoreboard bench for viterbi_acs_unit: a (7,5) encoder-based trellis model predicts each
// decision word; the monitor pops and compares when the DUT presents output.
module tb_viterbi_acs_unit;
    localparam int PM_W      = 12;
    localparam int FRAME_LEN = 4;
    localparam int INIT_PM   = 1024;
    localparam int PM_MAX    = (1 << (PM_W - 1)) - 1;
    localparam int PM_MIN    = -(1 << (PM_W - 1));

    logic              CLK = 1'b0;
    logic              RST;
    logic              in_valid;
    logic              start;
    logic signed [7:0] edge_00, edge_11, edge_10, edge_01;
    logic              dec_valid;
    logic [3:0]        dec;
    logic              dec_last;
    logic [1:0]        best_state;
    logic [4*PM_W-1:0] pm;
    logic              busy;

    viterbi_acs_unit #(.PM_W(PM_W), .FRAME_LEN(FRAME_LEN), .INIT_PM(INIT_PM)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .start(start),
        .edge_00(edge_00), .edge_11(edge_11), .edge_10(edge_10), .edge_01(edge_01),
        .dec_valid(dec_valid), .dec(dec), .dec_last(dec_last),
        .best_state(best_state), .pm(pm), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]        dec;
        logic              last;
        logic [1:0]        best;
        logic [4*PM_W-1:0] pm;
        int                cyc;
    } sb_t;

    sb_t q[$];
    int  n_chk  = 0;
    int  n_pass = 0;
    int  cyc    = 0;
    bit  m_run  = 1'b0;
    int  m_steps = 0;
    int  m_pm[4] = '{0, 0, 0, 0};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int edge_of(input int g1, input int g2,
                                   input int e00, input int e11, input int e10, input int e01);
        case ({g1[0], g2[0]})
            2'b00:   return e00;
            2'b11:   return e11;
            2'b10:   return e10;
            default: return e01;
        endcase
    endfunction

    always @(posedge CLK) cyc = cyc + 1;

    // One driven cycle; the model uses the encoder equations g1=u^u1^u2, g2=u^u2.
    task automatic step(input bit v, input bit st, input int e00, input int e11,
                        input int e10, input int e01);
        int  prev[4];
        int  nxt[4];
        int  c[2];
        int  mn, p, u, bm;
        sb_t it;
        @(negedge CLK);
        chk("busy", busy, m_run);
        in_valid = v;
        start    = st;
        edge_00  = e00[7:0];
        edge_11  = e11[7:0];
        edge_10  = e10[7:0];
        edge_01  = e01[7:0];
        if (v && (st || m_run)) begin
            if (st) begin
                prev    = '{0, INIT_PM, INIT_PM, INIT_PM};
                m_steps = 0;
            end else begin
                prev = m_pm;
            end
            mn = prev[0];
            for (int k = 1; k < 4; k++) if (prev[k] < mn) mn = prev[k];
            it.dec = 4'b0000;
            for (int ns = 0; ns < 4; ns++) begin
                u = ns >> 1;
                for (int b = 0; b < 2; b++) begin
                    p = (ns & 1) * 2 + b;
                    c[b] = prev[p] + edge_of(u ^ (p >> 1) ^ (p & 1), u ^ (p & 1),
                                             e00, e11, e10, e01);
                end
                it.dec[ns] = (c[1] < c[0]);
                nxt[ns] = (it.dec[ns] ? c[1] : c[0]) - mn;
                if (nxt[ns] > PM_MAX) nxt[ns] = PM_MAX;
                if (nxt[ns] < PM_MIN) nxt[ns] = PM_MIN;
                it.pm[ns*PM_W +: PM_W] = nxt[ns][PM_W-1:0];
            end
            bm = 0;
            for (int k = 1; k < 4; k++) if (nxt[k] < nxt[bm]) bm = k;
            it.best = bm[1:0];
            it.last = (m_steps == FRAME_LEN - 1);
            it.cyc  = cyc;
            m_steps++;
            m_run = !it.last;
            m_pm  = nxt;
            q.push_back(it);
        end
    endtask

    sb_t mon_it;
    bit  mon_exp;
    always @(negedge CLK) begin
        mon_exp = (q.size() > 0) && (q[0].cyc + 1 == cyc);
        chk("dec_valid", dec_valid, mon_exp);
        if (mon_exp) begin
            mon_it = q.pop_front();
            if (dec_valid) begin
                chk("dec", dec, mon_it.dec);
                chk("dec_last", dec_last, mon_it.last);
                chk("pm", pm, mon_it.pm);
                if (mon_it.last) chk("best_state", best_state, mon_it.best);
            end
        end
    end

    initial begin
        RST = 1'b1; in_valid = 1'b1; start = 1'b1;
        edge_00 = 8'sd5; edge_11 = 8'sd5; edge_10 = 8'sd5; edge_01 = 8'sd5;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0; in_valid = 1'b0; start = 1'b0;
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_dec", dec, 0);
        chk("rst_dec_last", dec_last, 0);
        chk("rst_best", best_state, 0);
        chk("rst_pm", pm, 0);
        chk("rst_busy", busy, 0);

        // Directed steps from the start of a frame.
        step(1, 1, 0, 4, 2, 2);
        step(1, 0, 4, 0, 2, 2);
        step(1, 0, 0, 4, 4, 0);
        step(0, 0, 0, 0, 0, 0);

        // Full frame; a trailing in_valid without start must be ignored.
        step(1, 1, 0, 6, 6, 6);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 6, 6, 6);
        step(1, 0, 0, 6, 6, 6);
        step(0, 0, 0, 0, 0, 0);

        // Restart on the third step, with a hold cycle mid-frame.
        step(1, 1, 3, -2, 1, 0);
        step(1, 0, -5, 7, 2, -1);
        step(0, 0, 9, 9, 9, 9);
        step(1, 1, 1, 2, 3, 4);
        for (int i = 0; i < 3; i++) step(1, 0, 4 - i, i, -i, 2);
        step(0, 0, 0, 0, 0, 0);

        // Equal edges everywhere: ties must resolve to P0.
        for (int i = 0; i < 200; i++) step(1, !m_run, -128, -128, -128, -128);

        // Random traffic with gaps and occasional restarts.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 m_run ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1),
                 int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        end

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        chk("sb_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
